rle_decompressor: RTL and testbench

Receive-side counterpart of the row compressor: consumes the byte stream recovered by the UART receiver, expands run-length pairs back into samples, and emits YUV422 pixels one row at a time. It sits between the UART RX byte output and the display/frame-buffer pixel sink. U and V samples are buffered internally so Y can be streamed out directly with its shared chroma.

---
 rtl/rle_decompressor.sv | 183 ++++++++++++++++++
 tb/tb_rle_decompressor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rle_decompressor.sv
// Run-length decoder that rebuilds one YUV422 row from the UART byte stream.
// Rows arrive as U, V and Y segments of {count, value} pairs. Each Y sample is paired with its buffered chroma.
module rle_decompressor #(
    parameter int RowPixelWidth = 640,
    parameter int PixelSize     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [7:0]           i_byte,
    input  logic                 i_valid,
    output logic                 o_in_ready,
    input  logic                 i_row_sync,
    output logic [PixelSize-1:0] o_pixel,
    output logic                 o_valid,
    input  logic                 i_out_ready,
    output logic                 o_row_done,
    output logic                 o_error
);

    localparam int IW   = $clog2(RowPixelWidth) + 1;
    localparam int HALF = RowPixelWidth / 2;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int CW   = (IW > 8) ? IW : 8;
    localparam logic [IW-1:0] HALF_N = IW'(HALF);
    localparam logic [IW-1:0] FULL_N = IW'(RowPixelWidth);

    typedef enum logic [1:0] {S_CNT, S_VAL, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {SEG_U, SEG_V, SEG_Y} seg_t;

    state_t                 state, state_nxt;
    seg_t                   seg, seg_nxt;
    logic [IW-1:0]          index, index_nxt;
    logic [IW-1:0]          remaining, remaining_nxt;
    logic [7:0]             run_left, run_left_nxt;
    logic [7:0]             value, value_nxt;
    logic [PixelSize-1:0]   pixel_nxt;
    logic                   valid_nxt;
    logic                   row_done_nxt;
    logic                   error_nxt;
    logic                   u_we, v_we;
    logic                   in_xfer;
    logic                   out_xfer;
    logic [IW-1:0]          rd_idx;
    logic [HW-1:0]          rd_half;
    logic [HW-1:0]          wr_addr;
    logic [7:0]             chroma;

    logic [7:0] ubuf [HALF];
    logic [7:0] vbuf [HALF];

    assign o_in_ready = (state == S_CNT) || (state == S_VAL);
    assign in_xfer    = i_valid && o_in_ready;
    assign out_xfer   = o_valid && i_out_ready;

    // The output pixel is registered, so chroma is looked up for the sample about to be presented next.
    assign rd_idx  = (state == S_RUN) ? index + IW'(1) : index;
    assign rd_half = HW'(rd_idx >> 1);
    assign chroma  = rd_idx[0] ? vbuf[rd_half] : ubuf[rd_half];
    assign wr_addr = HW'(index);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_CNT;
            seg        <= SEG_U;
            index      <= '0;
            remaining  <= HALF_N;
            run_left   <= '0;
            value      <= '0;
            o_pixel    <= '0;
            o_valid    <= 1'b0;
            o_row_done <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            state      <= state_nxt;
            seg        <= seg_nxt;
            index      <= index_nxt;
            remaining  <= remaining_nxt;
            run_left   <= run_left_nxt;
            value      <= value_nxt;
            o_pixel    <= pixel_nxt;
            o_valid    <= valid_nxt;
            o_row_done <= row_done_nxt;
            o_error    <= error_nxt;
        end
    end

    // Chroma buffers need no reset: every entry is rewritten before the Y segment reads it.
    always_ff @(posedge CLK) begin
        if (u_we) ubuf[wr_addr] <= value;
        if (v_we) vbuf[wr_addr] <= value;
    end

    always_comb begin
        state_nxt     = state;
        seg_nxt       = seg;
        index_nxt     = index;
        remaining_nxt = remaining;
        run_left_nxt  = run_left;
        value_nxt     = value;
        pixel_nxt     = o_pixel;
        valid_nxt     = o_valid;
        row_done_nxt  = 1'b0;
        error_nxt     = 1'b0;
        u_we          = 1'b0;
        v_we          = 1'b0;

        if (i_row_sync) begin
            state_nxt     = S_CNT;
            seg_nxt       = SEG_U;
            index_nxt     = '0;
            remaining_nxt = HALF_N;
            valid_nxt     = 1'b0;
        end else begin
            case (state)
                S_CNT: begin
                    if (in_xfer) begin
                        if (i_byte == 8'd0 || CW'(i_byte) > CW'(remaining)) begin
                            error_nxt     = 1'b1;
                            seg_nxt       = SEG_U;
                            index_nxt     = '0;
                            remaining_nxt = HALF_N;
                        end else begin
                            run_left_nxt = i_byte;
                            state_nxt    = S_VAL;
                        end
                    end
                end
                S_VAL: begin
                    if (in_xfer) begin
                        value_nxt = i_byte;
                        state_nxt = S_RUN;
                        if (seg == SEG_Y) begin
                            pixel_nxt = PixelSize'({i_byte, chroma});
                            valid_nxt = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (seg != SEG_Y) begin
                        u_we          = (seg == SEG_U);
                        v_we          = (seg == SEG_V);
                        index_nxt     = index + IW'(1);
                        run_left_nxt  = run_left - 8'd1;
                        remaining_nxt = remaining - IW'(1);
                        if (run_left == 8'd1) begin
                            state_nxt = S_CNT;
                            if (remaining == IW'(1)) begin
                                seg_nxt       = (seg == SEG_U) ? SEG_V : SEG_Y;
                                index_nxt     = '0;
                                remaining_nxt = (seg == SEG_U) ? HALF_N : FULL_N;
                            end
                        end
                    end else if (out_xfer) begin
                        index_nxt     = index + IW'(1);
                        run_left_nxt  = run_left - 8'd1;
                        remaining_nxt = remaining - IW'(1);
                        if (run_left == 8'd1) begin
                            valid_nxt = 1'b0;
                            if (remaining == IW'(1)) begin
                                state_nxt     = S_DONE;
                                row_done_nxt  = 1'b1;
                                seg_nxt       = SEG_U;
                                index_nxt     = '0;
                                remaining_nxt = HALF_N;
                            end else begin
                                state_nxt = S_CNT;
                            end
                        end else begin
                            pixel_nxt = PixelSize'({value, chroma});
                        end
                    end
                end
                S_DONE: begin
                    state_nxt = S_CNT;
                end
                default: begin
                    state_nxt = S_CNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rle_decompressor.sv
// Table-driven bench for rle_decompressor at RowPixelWidth=8: each record is a byte stream plus expected pixels and pulses.
module tb_rle_decompressor;

    localparam int W = 8;

    logic        CLK;
    logic        RST;
    logic [7:0]  i_byte;
    logic        i_valid;
    logic        o_in_ready;
    logic        i_row_sync;
    logic [15:0] o_pixel;
    logic        o_valid;
    logic        i_out_ready;
    logic        o_row_done;
    logic        o_error;

    int total = 0;
    int bad   = 0;

    rle_decompressor #(.RowPixelWidth(W), .PixelSize(16)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_byte      (i_byte),
        .i_valid     (i_valid),
        .o_in_ready  (o_in_ready),
        .i_row_sync  (i_row_sync),
        .o_pixel     (o_pixel),
        .o_valid     (o_valid),
        .i_out_ready (i_out_ready),
        .o_row_done  (o_row_done),
        .o_error     (o_error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [127:0] stream;
        logic [7:0]   nbytes;
        logic [7:0]   stall_at;
        logic [7:0]   stall_len;
        logic [7:0]   sync_at;
        logic [7:0]   exp_err;
        logic [7:0]   exp_npix;
        logic [7:0]   exp_done;
        logic [127:0] pix;
    } vec_t;

    localparam logic [127:0] ROW     = 128'h0410_0220_0221_0880_0000_0000_0000_0000;
    localparam logic [127:0] ROW_PIX = 128'h8010_8020_8010_8020_8010_8021_8010_8021;
    localparam logic [127:0] CNT00   = 128'h0000_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [127:0] CNT05   = 128'h0500_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [7:0]   NONE    = 8'hFF;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    function automatic vec_t make_vec(input logic [127:0] stream, input int nbytes,
                                      input logic [7:0] stall_at, input int stall_len,
                                      input logic [7:0] sync_at, input int exp_err,
                                      input int exp_npix, input int exp_done);
        vec_t r;
        r.stream    = stream;
        r.nbytes    = 8'(nbytes);
        r.stall_at  = stall_at;
        r.stall_len = 8'(stall_len);
        r.sync_at   = sync_at;
        r.exp_err   = 8'(exp_err);
        r.exp_npix  = 8'(exp_npix);
        r.exp_done  = 8'(exp_done);
        r.pix       = ROW_PIX;
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one record cycle by cycle; outputs are sampled and inputs updated on the falling edge.
    task automatic apply_stimulus(input int v);
        vec_t t;
        int   ptr, npix, nerr, ndone, stalls, cyc, quiet;
        int   last_cons, first_pix, last_pix, err_cyc, done_cyc;
        bit   synced, check_drop;
        logic [15:0] exp_p;
        t = vecs[v];
        ptr = 0; npix = 0; nerr = 0; ndone = 0; stalls = 0; cyc = 0; quiet = -1;
        last_cons = -100; first_pix = -100; last_pix = -100; err_cyc = -100; done_cyc = -100;
        synced = 1'b0; check_drop = 1'b0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (check_drop) begin
                check_output($sformatf("v%0d_sync_drop", v), 32'(o_valid), 32'd0);
                check_drop = 1'b0;
            end
            if (o_error) begin
                nerr++;
                err_cyc = cyc;
            end
            if (o_row_done) begin
                ndone++;
                done_cyc = cyc;
                check_output($sformatf("v%0d_done_in_ready", v), 32'(o_in_ready), 32'd0);
            end
            i_row_sync  = 1'b0;
            i_out_ready = 1'b1;
            if (o_valid && !synced && npix == int'(t.sync_at)) begin
                i_row_sync  = 1'b1;
                i_out_ready = 1'b0;
                synced      = 1'b1;
                check_drop  = 1'b1;
            end else if (o_valid && npix == int'(t.stall_at) && stalls < int'(t.stall_len)) begin
                i_out_ready = 1'b0;
                stalls++;
                exp_p = t.pix[127-16*npix -: 16];
                check_output($sformatf("v%0d_stall_hold%0d", v, stalls), 32'(o_pixel), 32'(exp_p));
            end
            if (o_valid && i_out_ready) begin
                if (npix == 0) first_pix = cyc;
                last_pix = cyc;
                if (npix < int'(t.exp_npix)) begin
                    exp_p = t.pix[127-16*npix -: 16];
                    check_output($sformatf("v%0d_pix%0d", v, npix), 32'(o_pixel), 32'(exp_p));
                end
                npix++;
            end
            if (ptr < int'(t.nbytes)) begin
                i_valid = 1'b1;
                i_byte  = t.stream[127-8*ptr -: 8];
                if (o_in_ready && !i_row_sync) begin
                    ptr++;
                    last_cons = cyc;
                end
            end else begin
                i_valid = 1'b0;
                i_byte  = 8'h00;
            end
            if (quiet < 0 && ptr == int'(t.nbytes) && (ndone > 0 || nerr > 0 || synced)) quiet = 3;
            if (quiet > 0) quiet--;
            if (quiet == 0) break;
            if (cyc > 150) begin
                total++;
                bad++;
                $display("[TB] FAIL v%0d_timeout: got no completion after %0d cycles, expected completion", v, cyc);
                break;
            end
        end
        i_valid     = 1'b0;
        i_row_sync  = 1'b0;
        i_out_ready = 1'b1;
        check_output($sformatf("v%0d_npix", v), 32'(npix), 32'(t.exp_npix));
        check_output($sformatf("v%0d_nerr", v), 32'(nerr), 32'(t.exp_err));
        check_output($sformatf("v%0d_ndone", v), 32'(ndone), 32'(t.exp_done));
        if (t.exp_err != 0) begin
            check_output($sformatf("v%0d_err_latency", v), 32'(err_cyc - last_cons), 32'd1);
        end else begin
            check_output($sformatf("v%0d_first_pix_latency", v), 32'(first_pix - last_cons), 32'd1);
            check_output($sformatf("v%0d_pix_span", v), 32'(last_pix - first_pix),
                         32'(int'(t.exp_npix) - 1 + ((t.stall_at != NONE) ? int'(t.stall_len) : 0)));
        end
        if (t.exp_done != 0) begin
            check_output($sformatf("v%0d_done_latency", v), 32'(done_cyc - last_pix), 32'd1);
        end
    endtask

    initial begin
        vecs[0] = make_vec(ROW,   8, NONE,  0, NONE,  0, 8, 1);
        vecs[1] = make_vec(ROW,   8, NONE,  0, NONE,  0, 8, 1);
        vecs[2] = make_vec(ROW,   8, 8'd3,  3, NONE,  0, 8, 1);
        vecs[3] = make_vec(CNT00, 1, NONE,  0, NONE,  1, 0, 0);
        vecs[4] = make_vec(ROW,   8, NONE,  0, NONE,  0, 8, 1);
        vecs[5] = make_vec(CNT05, 1, NONE,  0, NONE,  1, 0, 0);
        vecs[6] = make_vec(ROW,   8, NONE,  0, NONE,  0, 8, 1);
        vecs[7] = make_vec(ROW,   8, NONE,  0, 8'd3,  0, 3, 0);
        vecs[8] = make_vec(ROW,   8, NONE,  0, NONE,  0, 8, 1);

        // Reset held with random inputs: outputs must stay at their reset values.
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            i_byte      = 8'($urandom);
            i_valid     = 1'($urandom);
            i_row_sync  = 1'($urandom);
            i_out_ready = 1'($urandom);
        end
        @(negedge CLK);
        check_output("rst_pixel",    32'(o_pixel),    32'd0);
        check_output("rst_valid",    32'(o_valid),    32'd0);
        check_output("rst_in_ready", 32'(o_in_ready), 32'd1);
        check_output("rst_row_done", 32'(o_row_done), 32'd0);
        check_output("rst_error",    32'(o_error),    32'd0);
        i_byte = 8'h00; i_valid = 1'b0; i_row_sync = 1'b0; i_out_ready = 1'b1;
        RST = 1'b1;
        @(negedge CLK);
        check_output("post_rst_in_ready", 32'(o_in_ready), 32'd1);

        for (int v = 0; v < NVEC; v++) apply_stimulus(v);

        // Reset in the middle of a U run must discard the partial row.
        @(negedge CLK);
        i_valid = 1'b1; i_byte = 8'h04;
        @(negedge CLK);
        i_byte = 8'h10;
        @(negedge CLK);
        i_valid = 1'b0;
        @(negedge CLK);
        check_output("midrun_busy", 32'(o_in_ready), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check_output("midrun_rst_in_ready", 32'(o_in_ready), 32'd1);
        check_output("midrun_rst_valid",    32'(o_valid),    32'd0);
        RST = 1'b1;
        apply_stimulus(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
